// File: rtl/disp_pkg.sv
// Shared constants, types and helpers for the multiplexed digit display path.
package disp_pkg;
   localparam int DEF_N_CH     = 6;
   localparam int DEF_W        = 4;
   localparam int DEF_PRESCALE = 1000;
   localparam int DEF_DEAD     = 1;

   typedef logic [DEF_W-1:0] digit_t;

   localparam digit_t BCD_ZERO = digit_t'(0);
   localparam digit_t BCD_MAX  = digit_t'(9);

   // Index width for a selector over n entries; never narrower than one bit.
   function automatic int slot_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/disp_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled and pulses tick on the wrap cycle.
module disp_tick_gen
   import disp_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        clr,
   output logic [$clog2(PRESCALE)-1:0] cnt,
   output logic                        tick
);
   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   assign tick = en && !clr && (cnt_reg == CW'(PRESCALE - 1));

   always_comb begin
      cnt_next = cnt_reg;
      if (clr || tick) begin
         cnt_next = '0;
      end else if (en) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt = cnt_reg;
endmodule

// File: rtl/disp_scan_mux.sv
// N-channel time-multiplexed digit selector with dead time and double-buffered frame data.
// Define LEADING_ZERO_BLANK_EN to keep digit enables off for leading zero digits above slot 0.
module disp_scan_mux
   import disp_pkg::*;
#(
   parameter int N_CH     = DEF_N_CH,
   parameter int W        = DEF_W,
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int DEAD     = DEF_DEAD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [N_CH*W-1:0]        data_in,
   input  logic                     load,
   output logic [W-1:0]             digit_out,
   output logic [N_CH-1:0]          digit_sel,
   output logic [$clog2(N_CH)-1:0]  slot_idx,
   output logic                     frame_done
);
   localparam int SW = slot_width(N_CH);
   localparam int CW = $clog2(PRESCALE);

   typedef logic [N_CH-1:0][W-1:0] bank_t;

   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic            tick;
   logic            wrap;
   logic [SW-1:0]   slot_reg;
   logic [SW-1:0]   slot_next;
   bank_t           shadow_reg, shadow_next;
   bank_t           active_reg, active_next;
   logic            pending_reg, pending_next;
   logic            en_reg;
   logic            lit_next;
   logic [W-1:0]    digit_reg;
   logic [N_CH-1:0] sel_reg;
   logic            done_reg;

   disp_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (~en),
      .cnt   (cnt),
      .tick  (tick)
   );

   assign wrap     = tick && (slot_reg == SW'(N_CH - 1));
   assign cnt_next = (!en || tick) ? '0 : cnt + 1'b1;

   always_comb begin
      slot_next = slot_reg;
      if (!en || wrap) begin
         slot_next = '0;
      end else if (tick) begin
         slot_next = slot_reg + 1'b1;
      end
   end

   // A load landing on the wrap edge bypasses the shadow and goes live for the new frame.
   always_comb begin
      shadow_next  = shadow_reg;
      active_next  = active_reg;
      pending_next = pending_reg;
      if (load) begin
         shadow_next  = data_in;
         pending_next = 1'b1;
      end
      if (wrap) begin
         if (load) begin
            active_next = data_in;
         end else if (pending_reg) begin
            active_next = shadow_reg;
         end
         pending_next = 1'b0;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [N_CH-1:0] nz;
   logic [N_CH-1:0] blank;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_blank
         assign nz[gi] = |active_next[gi];
         if (gi == 0) begin : g_first
            assign blank[gi] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = ~|nz[N_CH-1:gi];
         end
      end
   endgenerate

   assign lit_next = en && (int'(cnt_next) >= DEAD) && !blank[slot_next];
`else
   assign lit_next = en && (int'(cnt_next) >= DEAD);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_reg  <= '0;
         active_reg  <= '0;
         pending_reg <= 1'b0;
         en_reg      <= 1'b0;
         slot_reg    <= '0;
         digit_reg   <= W'(BCD_ZERO);
         sel_reg     <= '0;
         done_reg    <= 1'b0;
      end else begin
         shadow_reg  <= shadow_next;
         active_reg  <= active_next;
         pending_reg <= pending_next;
         en_reg      <= en;
         slot_reg    <= slot_next;
         sel_reg     <= lit_next ? (N_CH'(1) << slot_next) : '0;
         done_reg    <= wrap;
         // Refresh on slot change and on the first edge after a disabled period.
         if (en && (tick || !en_reg)) begin
            digit_reg <= active_next[slot_next];
         end
      end
   end

   assign digit_out  = digit_reg;
   assign digit_sel  = sel_reg;
   assign slot_idx   = slot_reg;
   assign frame_done = done_reg;
endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed and randomised bench for disp_scan_mux against a frame-position reference model.
// With LEADING_ZERO_BLANK_EN defined, the model blanks leading zeros and extra cases run.
`timescale 1ns/1ps
module tb_disp_scan_mux;
   import disp_pkg::*;

   localparam int N_CH     = 4;
   localparam int W        = 4;
   localparam int PRESCALE = 4;
   localparam int DEAD     = 1;
   localparam int FRAME    = N_CH * PRESCALE;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              load = 1'b0;
   logic [N_CH*W-1:0] data_in = '0;
   logic [W-1:0]      digit_out;
   logic [N_CH-1:0]   digit_sel;
   logic [1:0]        slot_idx;
   logic              frame_done;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: position within the frame plus the two digit banks.
   int m_pos;
   bit m_run;
   bit m_pending;
   int m_active[N_CH];
   int m_shadow[N_CH];
   int e_digit, e_sel, e_slot, e_done;

   disp_scan_mux #(
      .N_CH     (N_CH),
      .W        (W),
      .PRESCALE (PRESCALE),
      .DEAD     (DEAD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .data_in    (data_in),
      .load       (load),
      .digit_out  (digit_out),
      .digit_sel  (digit_sel),
      .slot_idx   (slot_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic void model_reset();
      m_pos = 0;
      m_run = 0;
      m_pending = 0;
      for (int k = 0; k < N_CH; k++) begin
         m_active[k] = 0;
         m_shadow[k] = 0;
      end
      e_digit = 0;
      e_sel   = 0;
      e_slot  = 0;
      e_done  = 0;
   endfunction

   function automatic bit blanked(input int k);
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 0) return 1'b0;
      for (int j = k; j < N_CH; j++) begin
         if (m_active[j] != 0) return 1'b0;
      end
      return 1'b1;
`else
      return (k < 0);
`endif
   endfunction

   function automatic void model_step(input bit e, input bit l, input logic [N_CH*W-1:0] d);
      bit slot_end, frame_end;
      slot_end  = e && ((m_pos % PRESCALE) == PRESCALE - 1);
      frame_end = e && (m_pos == FRAME - 1);
      if (l) begin
         for (int k = 0; k < N_CH; k++) m_shadow[k] = int'((d >> (W * k)) & 'hF);
         m_pending = 1;
      end
      if (frame_end && m_pending) begin
         m_active  = m_shadow;
         m_pending = 0;
      end
      if (e) begin
         m_pos  = (m_pos + 1) % FRAME;
         e_slot = m_pos / PRESCALE;
         if (slot_end || !m_run) e_digit = m_active[e_slot];
         e_sel  = ((m_pos % PRESCALE) >= DEAD && !blanked(e_slot)) ? (1 << e_slot) : 0;
         e_done = frame_end ? 1 : 0;
      end else begin
         m_pos  = 0;
         e_slot = 0;
         e_sel  = 0;
         e_done = 0;
      end
      m_run = e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("digit_out",  32'(digit_out),  32'(e_digit));
      check("digit_sel",  32'(digit_sel),  32'(e_sel));
      check("slot_idx",   32'(slot_idx),   32'(e_slot));
      check("frame_done", 32'(frame_done), 32'(e_done));
   endtask

   task automatic cycle(input bit e, input bit l, input logic [N_CH*W-1:0] d);
      en      = e;
      load    = l;
      data_in = d;
      @(posedge clk);
      model_step(e, l, d);
      #1;
      $display("t=%0t en=%0b load=%0b data=%h slot=%0d sel=%b digit=%h done=%0b",
               $time, e, l, d, slot_idx, digit_sel, digit_out, frame_done);
      check_all();
   endtask

   task automatic run_until(input int target);
      int budget;
      budget = 0;
      while (m_pos != target && budget < 2 * FRAME) begin
         cycle(1'b1, 1'b0, '0);
         budget++;
      end
      check("reach_pos", 32'(m_pos), 32'(target));
   endtask

   function automatic logic [N_CH*W-1:0] rand_bcd();
      logic [N_CH*W-1:0] v;
      digit_t dg;
      v = '0;
      for (int k = 0; k < N_CH; k++) begin
         dg = digit_t'($urandom_range(0, int'(BCD_MAX)));
         v[k*W +: W] = dg;
      end
      return v;
   endfunction

   initial begin
      model_reset();
      #2;
      check_all();
      #8 rst_n = 1'b1;
      #1;

      // Load while idle; first frame still shows the old zeros.
      cycle(1'b0, 1'b1, 16'h4321);
      repeat (2 * FRAME) cycle(1'b1, 1'b0, '0);

      // Load during slot 1: current frame unaffected.
      run_until(PRESCALE + 1);
      cycle(1'b1, 1'b1, 16'h8765);
      repeat (2 * FRAME) cycle(1'b1, 1'b0, '0);

      // Load exactly on the wrap edge goes live in the frame starting there.
      run_until(FRAME - 1);
      cycle(1'b1, 1'b1, 16'hA0A0);
      repeat (2 * FRAME) cycle(1'b1, 1'b0, '0);

      // Scan disabled mid slot 2 for three cycles, then resumed.
      run_until(2 * PRESCALE + 1);
      repeat (3) cycle(1'b0, 1'b0, '0);
      repeat (FRAME + 2) cycle(1'b1, 1'b0, '0);

      // Asynchronous reset pulse mid-slot: outputs clear before the next edge.
      run_until(PRESCALE + 2);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      #4 rst_n = 1'b1;
      cycle(1'b0, 1'b1, 16'h1234);
      repeat (2 * FRAME) cycle(1'b1, 1'b0, '0);

      // Randomised enable, load and data.
      repeat (400) cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, rand_bcd());

`ifdef LEADING_ZERO_BLANK_EN
      cycle(1'b1, 1'b1, 16'h0045);
      repeat (2 * FRAME) cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 16'h0000);
      repeat (2 * FRAME) cycle(1'b1, 1'b0, '0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
